// File: rtl/keypad_entry.sv
// keypad_entry: debounced hex keypad and ENTER front end for the digital lock.
// One digit is held until ENTER commits it either as a new PIN or as a login
// attempt. A rising intrusion alert blocks all entry for a fixed window.
module keypad_entry #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 64,
  parameter int LOCKOUT_CYCLES  = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_raw,
  input  logic [3:0] key_code,
  input  logic       enter_raw,
  input  logic       mode_set,
  input  logic       intrusion_alert,
  output logic [3:0] pin,
  output logic [3:0] login_pin,
  output logic       set_pin,
  output logic       login,
  output logic       entry_busy,
  output logic       entry_timeout,
  output logic       locked_out
);

  // Debounce counter only has to reach DEBOUNCE_CYCLES-1.
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int MAXC = (TIMEOUT_CYCLES > LOCKOUT_CYCLES) ? TIMEOUT_CYCLES : LOCKOUT_CYCLES;
  localparam int CW = $clog2(MAXC) + 1;

  localparam logic [DW-1:0] DB_ZERO  = {DW{1'b0}};
  localparam logic [DW-1:0] DB_ONE   = DW'(1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] LO_LAST  = CW'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DIGIT   = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v == CNT_MAX) begin
      return v;
    end else begin
      return v + CNT_ONE;
    end
  endfunction

  // Index 0 is the hex key, index 1 is ENTER; both share one debouncer shape.
  logic [1:0]         raw_s;
  logic [1:0]         db_level_r;
  logic [1:0][DW-1:0] db_cnt_r;
  logic [1:0]         db_event_r;
  logic               key_ev_s;
  logic               ent_ev_s;
  logic               alert_prev_r;
  logic               intr_edge_s;

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [3:0]    digit_r;
  logic [3:0]    pin_r;
  logic [3:0]    login_pin_r;
  logic          set_pin_r;
  logic          login_r;
  logic          busy_r;
  logic          timeout_r;
  logic          locked_r;

  assign raw_s       = {enter_raw, key_raw};
  assign key_ev_s    = db_event_r[0];
  assign ent_ev_s    = db_event_r[1];
  assign intr_edge_s = intrusion_alert & ~alert_prev_r;

  // Debouncers: flip the accepted level after DEBOUNCE_CYCLES disagreeing samples
  // in a row; a flip to high produces a one-cycle press event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_level_r <= 2'b00;
      db_event_r <= 2'b00;
      db_cnt_r   <= {2{DB_ZERO}};
    end else begin
      for (int i = 0; i < 2; i++) begin
        db_event_r[i] <= 1'b0;
        if (raw_s[i] == db_level_r[i]) begin
          db_cnt_r[i] <= DB_ZERO;
        end else if (db_cnt_r[i] == DB_LAST) begin
          db_level_r[i] <= raw_s[i];
          db_cnt_r[i]   <= DB_ZERO;
          db_event_r[i] <= raw_s[i];
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + DB_ONE;
        end
      end
    end
  end

  // Remember last alert level so only a rising edge starts or restarts lockout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alert_prev_r <= 1'b0;
    end else begin
      alert_prev_r <= intrusion_alert;
    end
  end

  // Entry sequencer: capture, commit, expire, and lockout, with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      digit_r     <= 4'h0;
      pin_r       <= 4'h0;
      login_pin_r <= 4'h0;
      set_pin_r   <= 1'b0;
      login_r     <= 1'b0;
      busy_r      <= 1'b0;
      timeout_r   <= 1'b0;
      locked_r    <= 1'b0;
    end else begin
      set_pin_r <= 1'b0;
      login_r   <= 1'b0;
      timeout_r <= 1'b0;
      if (intr_edge_s) begin
        state_r  <= ST_LOCKOUT;
        cnt_r    <= CNT_ZERO;
        digit_r  <= 4'h0;
        busy_r   <= 1'b0;
        locked_r <= 1'b1;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (key_ev_s) begin
              digit_r <= key_code;
              cnt_r   <= CNT_ZERO;
              busy_r  <= 1'b1;
              state_r <= ST_DIGIT;
            end else begin
              cnt_r <= CNT_ZERO;
            end
          end
          ST_DIGIT: begin
            // ENTER commits the held digit even if a new key or the expiry lands too.
            if (ent_ev_s) begin
              if (mode_set) begin
                pin_r     <= digit_r;
                set_pin_r <= 1'b1;
              end else begin
                login_pin_r <= digit_r;
                login_r     <= 1'b1;
              end
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end else if (key_ev_s) begin
              digit_r <= key_code;
              cnt_r   <= CNT_ZERO;
            end else if (cnt_r == TO_LAST) begin
              digit_r   <= 4'h0;
              timeout_r <= 1'b1;
              busy_r    <= 1'b0;
              state_r   <= ST_IDLE;
            end else begin
              cnt_r <= sat_inc(cnt_r);
            end
          end
          ST_LOCKOUT: begin
            if (cnt_r == LO_LAST) begin
              cnt_r    <= CNT_ZERO;
              locked_r <= 1'b0;
              state_r  <= ST_IDLE;
            end else begin
              cnt_r <= sat_inc(cnt_r);
            end
          end
          default: begin
            cnt_r    <= CNT_ZERO;
            busy_r   <= 1'b0;
            locked_r <= 1'b0;
            state_r  <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign pin           = pin_r;
  assign login_pin     = login_pin_r;
  assign set_pin       = set_pin_r;
  assign login         = login_r;
  assign entry_busy    = busy_r;
  assign entry_timeout = timeout_r;
  assign locked_out    = locked_r;

endmodule

// File: tb/tb_keypad_entry.sv
// Testbench for keypad_entry: directed scenarios plus randomized traffic,
// checked against a cycle-numbered reference model and a pulse scoreboard.
module tb_keypad_entry;

  localparam int DB = 4;
  localparam int TO = 64;
  localparam int LO = 128;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_raw = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       enter_raw = 1'b0;
  logic       mode_set = 1'b0;
  logic       intrusion_alert = 1'b0;
  logic [3:0] pin;
  logic [3:0] login_pin;
  logic       set_pin;
  logic       login;
  logic       entry_busy;
  logic       entry_timeout;
  logic       locked_out;

  keypad_entry #(
    .DEBOUNCE_CYCLES(DB),
    .TIMEOUT_CYCLES (TO),
    .LOCKOUT_CYCLES (LO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .key_raw        (key_raw),
    .key_code       (key_code),
    .enter_raw      (enter_raw),
    .mode_set       (mode_set),
    .intrusion_alert(intrusion_alert),
    .pin            (pin),
    .login_pin      (login_pin),
    .set_pin        (set_pin),
    .login          (login),
    .entry_busy     (entry_busy),
    .entry_timeout  (entry_timeout),
    .locked_out     (locked_out)
  );

  always #5 clk = ~clk;

  // kind: bit2 = set_pin, bit1 = login, bit0 = entry_timeout
  typedef struct {
    logic [2:0] kind;
    logic [3:0] code;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_set = 0;
  int n_login = 0;
  int n_to = 0;

  // Reference model: sample windows, deadlines and lockout end as absolute edge numbers.
  logic [DB-1:0] kh, eh;
  bit         kdown, edown, key_pend, ent_pend, alert_prev, have_digit;
  logic [3:0] m_digit, m_pin, m_login_pin;
  int         deadline, lock_end;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // A press is accepted once the last DB samples are all high; release once all low.
  task automatic db_step(inout logic [DB-1:0] hist, inout bit down, input logic sample, output bit ev);
    hist = {hist[DB-2:0], sample};
    ev = 1'b0;
    if (!down && (&hist)) begin
      down = 1'b1;
      ev = 1'b1;
    end else if (down && hist == '0) begin
      down = 1'b0;
    end
  endtask

  task automatic model_reset();
    kh = '0; eh = '0; kdown = 0; edown = 0; key_pend = 0; ent_pend = 0;
    alert_prev = 0; have_digit = 0; m_digit = 4'h0; m_pin = 4'h0; m_login_pin = 4'h0;
    deadline = 0; lock_end = -1;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit k_ev, e_ev, intr;
    exp_t e;
    cyc++;
    intr = intrusion_alert && !alert_prev;
    alert_prev = intrusion_alert;
    if (intr) begin
      lock_end = cyc + LO;
      have_digit = 0;
    end else if (cyc <= lock_end) begin
      have_digit = 0;
    end else if (have_digit) begin
      if (ent_pend) begin
        e.kind = mode_set ? 3'b100 : 3'b010;
        e.code = m_digit;
        e.cyc = cyc;
        exp_q.push_back(e);
        if (mode_set) m_pin = m_digit;
        else m_login_pin = m_digit;
        have_digit = 0;
      end else if (key_pend) begin
        m_digit = key_code;
        deadline = cyc + TO;
      end else if (cyc == deadline) begin
        e.kind = 3'b001;
        e.code = 4'h0;
        e.cyc = cyc;
        exp_q.push_back(e);
        have_digit = 0;
      end
    end else if (key_pend) begin
      have_digit = 1;
      m_digit = key_code;
      deadline = cyc + TO;
    end
    db_step(kh, kdown, key_raw, k_ev);
    db_step(eh, edown, enter_raw, e_ev);
    key_pend = k_ev;
    ent_pend = e_ev;
  endtask

  // Model process: advances on every rising edge, resets with the DUT.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else model_step();
    end
  end

  // Monitor: compares levels every cycle and pops the scoreboard on each pulse.
  initial begin
    exp_t e;
    logic [3:0] act_code;
    bit lock_b;
    forever begin
      @(negedge clk);
      if (rst) begin
        lock_b = (cyc < lock_end);
        check("levels", {pin, login_pin, entry_busy, locked_out},
              {m_pin, m_login_pin, have_digit, lock_b});
        if (set_pin || login || entry_timeout) begin
          act_code = set_pin ? pin : (login ? login_pin : 4'h0);
          if (set_pin) n_set++;
          if (login) n_login++;
          if (entry_timeout) n_to++;
          if (exp_q.size() == 0) begin
            check("unexpected_pulse", {set_pin, login, entry_timeout}, 3'b000);
          end else begin
            e = exp_q.pop_front();
            check("pulse_kind", {set_pin, login, entry_timeout}, e.kind);
            check("pulse_code", act_code, e.code);
            check("pulse_cycle", cyc, e.cyc);
          end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
          e = exp_q.pop_front();
          check("missing_pulse", {set_pin, login, entry_timeout}, e.kind);
        end
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_key(input logic [3:0] code, input int hold, input int gap);
    key_code = code;
    key_raw = 1'b1;
    tick(hold);
    key_raw = 1'b0;
    tick(gap);
  endtask

  task automatic press_enter(input logic mode, input int hold, input int gap);
    mode_set = mode;
    enter_raw = 1'b1;
    tick(hold);
    enter_raw = 1'b0;
    tick(gap);
  endtask

  // Stimulus: directed scenarios, then random traffic.
  initial begin
    int snap;
    int k;
    int op;
    tick(3);
    check("reset_outputs", {pin, login_pin, set_pin, login, entry_busy, entry_timeout, locked_out}, 13'h0);
    rst = 1'b1;
    tick(2);

    // Program then login
    press_key(4'hA, 10, 10);
    press_enter(1'b1, 10, 10);
    check("program_pin", pin, 4'hA);
    check("program_count", n_set, 1);
    press_key(4'hA, 10, 10);
    press_enter(1'b0, 10, 10);
    check("login_pin", login_pin, 4'hA);
    check("pin_kept", pin, 4'hA);
    check("login_count", n_login, 1);

    // Bounce
    key_code = 4'h1;
    key_raw = 1'b1; tick(1);
    key_raw = 1'b0; tick(1);
    key_raw = 1'b1; tick(2);
    key_raw = 1'b0; tick(1);
    key_raw = 1'b1;
    tick(4);
    check("bounce_busy_early", entry_busy, 1'b0);
    tick(1);
    check("bounce_busy_rise", entry_busy, 1'b1);
    tick(5);
    key_raw = 1'b0;
    tick(10);
    press_enter(1'b1, 50, 10);
    check("long_enter_single", n_set, 2);
    check("bounce_pin", pin, 4'h1);

    // Timeout
    press_key(4'h3, 6, 70);
    check("timeout_count", n_to, 1);
    check("timeout_busy", entry_busy, 1'b0);
    snap = n_set + n_login;
    press_enter(1'b0, 10, 10);
    check("enter_alone", n_set + n_login, snap);

    // Overwrite
    press_key(4'h5, 8, 8);
    press_key(4'h7, 8, 8);
    press_enter(1'b0, 8, 8);
    check("overwrite", login_pin, 4'h7);

    // Key and ENTER events in the same cycle
    press_key(4'h2, 8, 8);
    key_code = 4'h9; mode_set = 1'b1;
    key_raw = 1'b1; enter_raw = 1'b1;
    tick(10);
    key_raw = 1'b0; enter_raw = 1'b0;
    tick(10);
    check("race_commit", pin, 4'h2);
    check("race_idle", entry_busy, 1'b0);

    // Lockout
    press_key(4'h4, 8, 2);
    check("pre_lock_busy", entry_busy, 1'b1);
    snap = n_set + n_login;
    intrusion_alert = 1'b1;
    tick(1);
    intrusion_alert = 1'b0;
    check("lock_rise", locked_out, 1'b1);
    check("lock_discard", entry_busy, 1'b0);
    press_key(4'h8, 8, 8);
    press_enter(1'b1, 8, 8);
    tick(67);
    intrusion_alert = 1'b1;
    tick(1);
    intrusion_alert = 1'b0;
    k = 0;
    for (int i = 0; i < 400; i++) begin
      if (locked_out) k++;
      else break;
      tick(1);
    end
    check("lock_extend_len", k, LO);
    press_enter(1'b1, 8, 8);
    check("lock_no_strobe", n_set + n_login, snap);

    // Reset mid-entry
    press_key(4'h6, 8, 4);
    check("pre_reset_busy", entry_busy, 1'b1);
    snap = n_set + n_login;
    rst = 1'b0;
    #1;
    check("reset_mid", {pin, login_pin, set_pin, login, entry_busy, entry_timeout, locked_out}, 13'h0);
    tick(3);
    rst = 1'b1;
    tick(2);
    press_enter(1'b1, 10, 10);
    check("post_reset_no_strobe", n_set + n_login, snap);
    check("post_reset_pin", pin, 4'h0);

    // Random traffic
    for (int it = 0; it < 80; it++) begin
      op = int'($urandom_range(0, 9));
      if (op <= 3) begin
        key_code = 4'($urandom_range(0, 15));
        for (int b = 0; b < int'($urandom_range(0, 3)); b++) begin
          key_raw = 1'($urandom_range(0, 1));
          tick(1);
        end
        press_key(4'($urandom_range(0, 15)), int'($urandom_range(1, 10)), int'($urandom_range(1, 12)));
      end else if (op <= 6) begin
        for (int b = 0; b < int'($urandom_range(0, 3)); b++) begin
          enter_raw = 1'($urandom_range(0, 1));
          tick(1);
        end
        press_enter(1'($urandom_range(0, 1)), int'($urandom_range(1, 10)), int'($urandom_range(1, 12)));
      end else if (op == 7) begin
        key_code = 4'($urandom_range(0, 15));
        mode_set = 1'($urandom_range(0, 1));
        key_raw = 1'b1; enter_raw = 1'b1;
        tick(int'($urandom_range(3, 10)));
        key_raw = 1'b0; enter_raw = 1'b0;
        tick(int'($urandom_range(1, 12)));
      end else if (op == 8) begin
        tick(int'($urandom_range(10, 80)));
      end else begin
        if ($urandom_range(0, 3) == 0) begin
          intrusion_alert = 1'b1;
          tick(int'($urandom_range(1, 4)));
          intrusion_alert = 1'b0;
        end
        tick(5);
      end
    end

    tick(200);
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
